// File: rtl/divider_result_buf.sv
`default_nettype none
// ============================================================================
//  Module   : divider_result_buf
//  Purpose  : Result collector for the pipelined divider. Issued divisors are
//             tagged and carried through a latency-matched delay line. When a
//             tag exits, {divisor, merchant, remainder} is pushed into a small
//             FIFO that is drained over a valid/ready interface. The divider
//             cannot stall, so a result that arrives while the FIFO is full is
//             dropped and the sticky ovf flag is set.
//  Options  : DIV_RESULT_CHECK_EN adds the sticky chk_err output. It flags
//             results with remainder >= divisor or divisor == 0.
//  Revision : 1.0 - initial release
// ============================================================================
module divider_result_buf #(
    parameter int M      = 4,
    parameter int SERIES = 5,
    parameter int LAT    = 5,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [M-1:0]              in_divisor,
    input  logic [SERIES-1:0]         div_merchant,
    input  logic [M-1:0]              div_remainder,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [M-1:0]              out_divisor,
    output logic [SERIES-1:0]         out_merchant,
    output logic [M-1:0]              out_remainder,
    output logic                      ovf,
    output logic [$clog2(DEPTH):0]    level
`ifdef DIV_RESULT_CHECK_EN
    ,
    output logic                      chk_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = M + SERIES + M;
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    // Delay line: one {valid, divisor} pair per divider pipeline stage
    logic [LAT-1:0] dl_valid;
    logic [M-1:0]   dl_divisor [LAT];

    // FIFO storage and pointers (extra MSB keeps full and empty distinct)
    logic [DW-1:0]  mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic [DW-1:0]  head;

    logic           wr_req;
    logic           wr_en;
    logic           rd_en;
    logic           full;
    logic [DW-1:0]  wr_data;

    // Stage 0 samples the operation presented to the divider this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_valid[0]   <= 1'b0;
            dl_divisor[0] <= '0;
        end else begin
            dl_valid[0]   <= in_valid;
            dl_divisor[0] <= in_divisor;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < LAT; gi++) begin : g_stage
            // Remaining stages shift the tag forward every cycle
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dl_valid[gi]   <= 1'b0;
                    dl_divisor[gi] <= '0;
                end else begin
                    dl_valid[gi]   <= dl_valid[gi-1];
                    dl_divisor[gi] <= dl_divisor[gi-1];
                end
            end
        end
    endgenerate

    assign wr_req  = dl_valid[LAT-1];
    assign wr_data = {dl_divisor[LAT-1], div_merchant, div_remainder};
    assign full    = (level == LVL_FULL);
    assign rd_en   = out_valid & out_ready;
    // At full a simultaneous read frees the slot being written
    assign wr_en   = wr_req & (~full | rd_en);

    // Storage needs no reset; reads are gated by out_valid
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Pointer, occupancy and overflow bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (wr_req && full && !rd_en) begin
                ovf <= 1'b1;
            end
        end
    end

    assign out_valid = (level != '0);
    assign head      = mem[rd_ptr[AW-1:0]];

    // Head entry is presented combinationally and forced to zero when empty
    always_comb begin
        out_divisor   = '0;
        out_merchant  = '0;
        out_remainder = '0;
        if (out_valid) begin
            out_divisor   = head[DW-1 -: M];
            out_merchant  = head[M +: SERIES];
            out_remainder = head[M-1:0];
        end
    end

`ifdef DIV_RESULT_CHECK_EN
    logic bad_result;
    assign bad_result = (div_remainder >= dl_divisor[LAT-1]) ||
                        (dl_divisor[LAT-1] == '0);

    // Sticky flag for any inconsistent result, whether stored or dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_err <= 1'b0;
        end else if (wr_req && bad_result) begin
            chk_err <= 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_divider_result_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_result_buf
//  Purpose  : Directed self-checking bench for divider_result_buf
//             (M=4, SERIES=5, LAT=5, DEPTH=4). The bench plays the divider:
//             it returns the merchant/remainder chosen for each issued op
//             exactly LAT edges after the op was sampled.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_divider_result_buf;

    localparam int M      = 4;
    localparam int SERIES = 5;
    localparam int LAT    = 5;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic [M-1:0]      in_divisor;
    logic [SERIES-1:0] div_merchant;
    logic [M-1:0]      div_remainder;
    logic              out_valid;
    logic              out_ready;
    logic [M-1:0]      out_divisor;
    logic [SERIES-1:0] out_merchant;
    logic [M-1:0]      out_remainder;
    logic              ovf;
    logic [2:0]        level;
`ifdef DIV_RESULT_CHECK_EN
    logic              chk_err;
`endif

    int n_cmp  = 0;
    int n_fail = 0;
    int e      = 100;

    // Divider model history, indexed by the edge that samples the op
    logic              hist_v [64];
    logic [SERIES-1:0] hist_m [64];
    logic [M-1:0]      hist_r [64];

    divider_result_buf #(
        .M(M), .SERIES(SERIES), .LAT(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_divisor    (in_divisor),
        .div_merchant  (div_merchant),
        .div_remainder (div_remainder),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_divisor   (out_divisor),
        .out_merchant  (out_merchant),
        .out_remainder (out_remainder),
        .ovf           (ovf),
        .level         (level)
`ifdef DIV_RESULT_CHECK_EN
        ,
        .chk_err       (chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one edge pass, return 1 ns after it
    task automatic tick(input logic v, input logic [M-1:0] d,
                        input logic [SERIES-1:0] m, input logic [M-1:0] r,
                        input logic rdy);
        int nx;
        int src;
        nx  = (e + 1) % 64;
        src = (e + 1 - LAT) % 64;
        hist_v[nx] = v;
        hist_m[nx] = m;
        hist_r[nx] = r;
        in_valid   = v;
        in_divisor = d;
        out_ready  = rdy;
        if (hist_v[src]) begin
            div_merchant  = hist_m[src];
            div_remainder = hist_r[src];
        end else begin
            div_merchant  = 5'h1F;
            div_remainder = 4'hF;
        end
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic test_reset();
        #6;
        n_cmp++;
        if ({out_valid, level, ovf, out_divisor, out_merchant, out_remainder} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b lvl=%0d ovf=%b d=%0d m=%0d r=%0d want all 0",
                     out_valid, level, ovf, out_divisor, out_merchant, out_remainder);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_single();
        tick(1'b1, 4'd3, 5'd12, 4'd0, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early: out_valid got %b want 0", out_valid);
        end
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b0);
        n_cmp++;
        if ({out_valid, out_divisor, out_merchant, out_remainder, level} !== {1'b1, 4'd3, 5'd12, 4'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL single_result: got v=%b d=%0d m=%0d r=%0d lvl=%0d want v=1 d=3 m=12 r=0 lvl=1",
                     out_valid, out_divisor, out_merchant, out_remainder, level);
        end
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b1);
        n_cmp++;
        if ({out_valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL single_drain: got v=%b lvl=%0d want v=0 lvl=0", out_valid, level);
        end
    endtask

    task automatic test_burst();
        for (int c = 0; c < 4; c++) tick(1'b1, 4'(c + 2), 5'(c + 18), 4'(c + 1), 1'b0);
        for (int c = 4; c < 9; c++) tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b0);
        n_cmp++;
        if ({level, ovf, out_divisor} !== {3'd4, 1'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL burst_full: got lvl=%0d ovf=%b d=%0d want lvl=4 ovf=0 d=2", level, ovf, out_divisor);
        end
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b0);
        n_cmp++;
        if ({out_valid, out_divisor, out_merchant, out_remainder} !== {1'b1, 4'd2, 5'd18, 4'd1}) begin
            n_fail++;
            $display("FAIL burst_hold: got v=%b d=%0d m=%0d r=%0d want v=1 d=2 m=18 r=1",
                     out_valid, out_divisor, out_merchant, out_remainder);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({out_valid, out_divisor, out_merchant, out_remainder} !== {1'b1, 4'(k + 2), 5'(k + 18), 4'(k + 1)}) begin
                n_fail++;
                $display("FAIL burst_order[%0d]: got v=%b d=%0d m=%0d r=%0d want v=1 d=%0d m=%0d r=%0d",
                         k, out_valid, out_divisor, out_merchant, out_remainder, k + 2, k + 18, k + 1);
            end
            tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b1);
        end
        n_cmp++;
        if ({out_valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL burst_empty: got v=%b lvl=%0d want v=0 lvl=0", out_valid, level);
        end
    endtask

    task automatic test_overflow();
        for (int c = 0; c < 5; c++) tick(1'b1, 4'(c + 2), 5'(c + 18), 4'(c + 1), 1'b0);
        for (int c = 5; c < 9; c++) tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b0);
        n_cmp++;
        if ({level, ovf} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_before_drop: got lvl=%0d ovf=%b want lvl=4 ovf=0", level, ovf);
        end
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b0);
        n_cmp++;
        if ({level, ovf, out_divisor} !== {3'd4, 1'b1, 4'd2}) begin
            n_fail++;
            $display("FAIL ovf_drop: got lvl=%0d ovf=%b d=%0d want lvl=4 ovf=1 d=2", level, ovf, out_divisor);
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({out_valid, out_divisor, out_merchant} !== {1'b1, 4'(k + 2), 5'(k + 18)}) begin
                n_fail++;
                $display("FAIL ovf_order[%0d]: got v=%b d=%0d m=%0d want v=1 d=%0d m=%0d",
                         k, out_valid, out_divisor, out_merchant, k + 2, k + 18);
            end
            tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b1);
        end
        n_cmp++;
        if ({out_valid, level, ovf} !== {1'b0, 3'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL ovf_sticky: got v=%b lvl=%0d ovf=%b want v=0 lvl=0 ovf=1", out_valid, level, ovf);
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 3; c++) tick(1'b1, 4'(c + 7), 5'(c + 1), 4'd0, 1'b0);
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b1);
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b1);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, level, ovf} !== {1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b lvl=%0d ovf=%b want all 0", out_valid, level, ovf);
        end
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b1);
            n_cmp++;
            if ({out_valid, level} !== {1'b0, 3'd0}) begin
                n_fail++;
                $display("FAIL rst_stale[%0d]: got v=%b lvl=%0d want v=0 lvl=0", i, out_valid, level);
            end
        end
    endtask

    task automatic test_full_rw();
        for (int c = 0; c <= 20; c++) begin
            if (c >= 9) begin
                n_cmp++;
                if ({out_valid, out_divisor, out_merchant, out_remainder} !==
                    {1'b1, 4'(c - 8), 5'(c + 8), 4'(c - 9)}) begin
                    n_fail++;
                    $display("FAIL fullrw_order[%0d]: got v=%b d=%0d m=%0d r=%0d want v=1 d=%0d m=%0d r=%0d",
                             c, out_valid, out_divisor, out_merchant, out_remainder, c - 8, c + 8, c - 9);
                end
            end
            tick(c < 12, 4'(c + 1), 5'(c + 17), 4'(c), c >= 9);
            if (c >= 8 && c <= 16) begin
                n_cmp++;
                if ({level, ovf} !== {3'd4, 1'b0}) begin
                    n_fail++;
                    $display("FAIL fullrw_level[%0d]: got lvl=%0d ovf=%b want lvl=4 ovf=0", c, level, ovf);
                end
            end
        end
        n_cmp++;
        if ({out_valid, level, ovf} !== {1'b0, 3'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL fullrw_empty: got v=%b lvl=%0d ovf=%b want v=0 lvl=0 ovf=0", out_valid, level, ovf);
        end
    endtask

    task automatic test_check();
        tick(1'b1, 4'd4, 5'd1, 4'd5, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b0);
`ifdef DIV_RESULT_CHECK_EN
        n_cmp++;
        if (chk_err !== 1'b0) begin
            n_fail++;
            $display("FAIL chk_before: chk_err got %b want 0", chk_err);
        end
`endif
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b0);
        n_cmp++;
        if ({out_valid, out_divisor, out_merchant, out_remainder, level} !== {1'b1, 4'd4, 5'd1, 4'd5, 3'd1}) begin
            n_fail++;
            $display("FAIL chk_entry: got v=%b d=%0d m=%0d r=%0d lvl=%0d want v=1 d=4 m=1 r=5 lvl=1",
                     out_valid, out_divisor, out_merchant, out_remainder, level);
        end
`ifdef DIV_RESULT_CHECK_EN
        n_cmp++;
        if (chk_err !== 1'b1) begin
            n_fail++;
            $display("FAIL chk_set: chk_err got %b want 1", chk_err);
        end
`endif
        tick(1'b0, 4'd0, 5'd0, 4'd0, 1'b1);
        n_cmp++;
        if ({out_valid, level} !== {1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL chk_drain: got v=%b lvl=%0d want v=0 lvl=0", out_valid, level);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            hist_v[i] = 1'b0;
            hist_m[i] = '0;
            hist_r[i] = '0;
        end
        rst           = 1'b1;
        in_valid      = 1'b0;
        in_divisor    = '0;
        div_merchant  = '0;
        div_remainder = '0;
        out_ready     = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_reset_midflight();
        test_full_rw();
        test_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/divider_result_buf.md
Name: divider_result_buf

Overview:
- Downstream stage of the pipelined divider (divider_man).
- Tags each divisor issued into the divider with a valid bit and carries that tag through a delay line matched to the divider latency.
- When the tag exits the delay line, captures {divisor, merchant, remainder} into a small FIFO.
- Presents results on a valid/ready interface. The divider cannot stall, so results arriving at a full FIFO are dropped and flagged.

Parameters:
M, 4, divisor and remainder width; must equal the divider's M
SERIES, 5, merchant width; must equal the divider's SERIES
LAT, 5, divider latency in clk cycles from divisor sample to matching result; LAT >= 1
DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  divisor presented to the divider this cycle is a real operation
in_divisor  in  M  same value driven onto the divider's divisor port
div_merchant  in  SERIES  divider merchant output
div_remainder  in  M  divider remainder output
out_valid  out  1  FIFO head holds a result
out_ready  in  1  consumer accepts head this cycle
out_divisor  out  M  divisor of head result
out_merchant  out  SERIES  merchant of head result
out_remainder  out  M  remainder of head result
ovf  out  1  sticky: at least one result dropped on full FIFO
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, clk-synchronous release):
  - All delay-line valid bits, FIFO pointers, level and ovf go to 0.
  - out_valid = 0. out_divisor, out_merchant and out_remainder are 0.
  - Results in flight at reset are discarded. No result emerges from pre-reset in_valid.
- Delay line:
  - LAT-stage shift register of {valid, divisor}, advancing every clk.
  - Stage 0 loads {in_valid, in_divisor} at edge t.
  - The entry reaches the last stage at edge t+LAT-1.
  - At edge t+LAT, if the last-stage valid = 1, a write request occurs with {last-stage divisor, div_merchant, div_remainder} sampled at that edge.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH)+1 bits each; the MSB distinguishes full from empty.
  - wr_en = write request AND (level < DEPTH OR rd_en).
  - rd_en = out_valid AND out_ready.
- Timing:
  - No fall-through. A write at edge e makes out_valid = 1 after edge e.
  - Total in_valid-to-out_valid latency = LAT+1 edges.
- Output data: out_* are driven from the entry at the read pointer (registered storage, combinational select). They hold steady while out_valid = 1 and out_ready = 0.
- Simultaneous read and write:
  - At full: both occur and level stays DEPTH.
  - At empty: the write occurs; the read cannot, since out_valid = 0.
  - Level updates by +1, -1 or 0 accordingly.
- Overflow: a write request when level = DEPTH and rd_en = 0 drops the entry and sets ovf. ovf clears only on rst.
- Back-to-back issue: one in_valid per cycle is sustained. The FIFO absorbs bursts up to DEPTH while out_ready = 0.
- Wrap-around: pointers wrap modulo 2*DEPTH. Data order is strictly FIFO.

Optional Feature:
- Macro DIV_RESULT_CHECK_EN.
- Defined:
  - Adds output chk_err (1 bit, reset 0, sticky).
  - chk_err is set at any accepted or dropped write where div_remainder >= divisor (unsigned) or divisor == 0.
  - The offending entry is still written if space allows.
- Undefined: port chk_err and all check logic are absent; the module is otherwise identical.

Test Plan:
- Single op, LAT=5: rst high 7 ns then low; in_valid pulse with in_divisor=3 at edge 4; bench drives div_merchant=12, div_remainder=0 at edge 9 -> out_valid=1 after edge 9 with out_divisor=3, out_merchant=12, out_remainder=0, level=1; out_ready=1 empties it next edge.
- Burst with stall: in_valid 4 consecutive cycles with divisors 2,3,4,5 and out_ready=0 -> level reaches 4, ovf=0, out_divisor=2 held steady; then out_ready=1 -> outputs 2,3,4,5 in order on consecutive edges.
- Overflow: 5 consecutive ops with out_ready=0, DEPTH=4 -> fifth (divisor 6) dropped, ovf=1, level=4; draining yields 2..5 only; ovf stays 1 until rst.
- Full with simultaneous read/write: FIFO full, out_ready=1 held while results keep arriving every cycle -> level stays 4, ovf stays 0, no entry lost, order preserved across pointer wrap (12 ops).
- Reset mid-flight: 3 ops issued, rst asserted 2 cycles later for 1 cycle -> out_valid stays 0 thereafter, level=0, no stale results emerge.
- DIV_RESULT_CHECK_EN defined: op with divisor=4, div_remainder=5 -> chk_err=1 after that write edge; with macro undefined, same stimulus -> entry written normally, no chk_err port.
